// File: rtl/adder_pkg.sv
// ============================================================================
// Module  : adder_pkg
// Brief   : Shared types and constants for the multi-lane approximate accumulator.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

    typedef enum logic [1:0] {
        ADD_EXACT = 2'd0,
        ADD_LOA   = 2'd1,
        ADD_TRUNC = 2'd2
    } add_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    localparam int COUNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/adder_lane_approx.sv
// ============================================================================
// Module  : adder_lane_approx
// Brief   : Combinational single-lane adder (exact / LOA / truncated).
//           ACC_SAT_EN enables overflow detection and clamping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_lane_approx
    import adder_pkg::*;
#(
    parameter int WIDTH_IN   = 16,
    parameter int WIDTH_ACC  = 24,
    parameter int IGNORE_BIT = 4,
    parameter int SIGNED     = 0
) (
    input  logic [1:0]           mode_i,
    input  logic [WIDTH_ACC-1:0] acc_i,
    input  logic [WIDTH_IN-1:0]  data_i,
    output logic [WIDTH_ACC-1:0] sum_o,
    output logic                 ovf_o
);

    localparam int HI_W = WIDTH_ACC - IGNORE_BIT;
    localparam int MSB  = WIDTH_ACC - 1;

    logic [WIDTH_ACC-1:0]  w_b;
    logic [IGNORE_BIT:0]   w_lo_exact;
    logic [IGNORE_BIT-1:0] w_lo;
    logic                  w_cin;

    always_comb begin
        if (SIGNED != 0) begin
            w_b = WIDTH_ACC'($signed(data_i));
        end else begin
            w_b = WIDTH_ACC'(data_i);
        end
    end

    // Low part and the carry it feeds into the upper part, per mode.
    always_comb begin
        w_lo_exact = {1'b0, acc_i[IGNORE_BIT-1:0]} + {1'b0, w_b[IGNORE_BIT-1:0]};
        w_lo       = w_lo_exact[IGNORE_BIT-1:0];
        w_cin      = w_lo_exact[IGNORE_BIT];
        case (add_mode_e'(mode_i))
            ADD_LOA: begin
                w_lo  = acc_i[IGNORE_BIT-1:0] | w_b[IGNORE_BIT-1:0];
                w_cin = acc_i[IGNORE_BIT-1] & w_b[IGNORE_BIT-1];
            end
            ADD_TRUNC: begin
                w_lo  = '0;
                w_cin = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef ACC_SAT_EN
    logic [HI_W:0]        w_hi;
    logic [WIDTH_ACC-1:0] w_raw;
    logic                 w_ovf;

    always_comb begin
        w_hi  = {1'b0, acc_i[MSB:IGNORE_BIT]} + {1'b0, w_b[MSB:IGNORE_BIT]} + (HI_W+1)'(w_cin);
        w_raw = {w_hi[HI_W-1:0], w_lo};
        if (SIGNED != 0) begin
            w_ovf = (acc_i[MSB] == w_b[MSB]) && (w_raw[MSB] != acc_i[MSB]);
        end else begin
            w_ovf = w_hi[HI_W];
        end
        sum_o = w_raw;
        if (w_ovf) begin
            if (SIGNED != 0) begin
                sum_o = w_b[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
            end else begin
                sum_o = '1;
            end
        end
    end

    assign ovf_o = w_ovf;
`else
    assign sum_o = {acc_i[MSB:IGNORE_BIT] + w_b[MSB:IGNORE_BIT] + HI_W'(w_cin), w_lo};
    assign ovf_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/adder_accum_lanes.sv
// ============================================================================
// Module  : adder_accum_lanes
// Brief   : Multi-lane streaming frame accumulator with run-time adder mode.
//           Optional macro ACC_SAT_EN: saturating lanes with sticky out_ovf_o.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_accum_lanes
    import adder_pkg::*;
#(
    parameter int LANES      = 4,
    parameter int WIDTH_IN   = 16,
    parameter int WIDTH_ACC  = 24,
    parameter int IGNORE_BIT = 4,
    parameter int SIGNED     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       in_first_i,
    input  logic                       in_last_i,
    input  logic [LANES*WIDTH_IN-1:0]  in_data_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [LANES*WIDTH_ACC-1:0] out_data_o,
    output logic [COUNT_W-1:0]         out_count_o,
    output logic [LANES-1:0]           out_ovf_o
);

    state_e                     state_q, state_d;
    logic [1:0]                 mode_q, mode_d;
    logic [LANES*WIDTH_ACC-1:0] acc_q, acc_d;
    logic [LANES*WIDTH_ACC-1:0] out_data_q, out_data_d;
    logic [COUNT_W-1:0]         cnt_q, cnt_d;
    logic [COUNT_W-1:0]         out_count_q, out_count_d;
    logic [LANES-1:0]           sticky_q, sticky_d;
    logic [LANES-1:0]           out_ovf_q, out_ovf_d;
    logic                       out_valid_q, out_valid_d;

    logic                       w_accept;
    logic                       w_start;
    logic [1:0]                 w_mode;
    logic [LANES*WIDTH_ACC-1:0] w_sum;
    logic [LANES-1:0]           w_ovf;
    logic [COUNT_W-1:0]         w_cnt_next;
    logic [LANES-1:0]           w_sticky_next;

    assign in_ready_o    = (state_q != HOLD) && !rst;
    assign w_accept      = in_valid_i && in_ready_o;
    // Any beat taken in IDLE opens a frame; in_first mid-frame restarts it.
    assign w_start       = (state_q == IDLE) || in_first_i;
    assign w_mode        = w_start ? mode_i : mode_q;
    assign w_cnt_next    = w_start ? COUNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + COUNT_W'(1));
    assign w_sticky_next = w_start ? w_ovf : (sticky_q | w_ovf);

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [WIDTH_ACC-1:0] w_a;
            assign w_a = w_start ? '0 : acc_q[i*WIDTH_ACC +: WIDTH_ACC];

            adder_lane_approx #(
                .WIDTH_IN   (WIDTH_IN),
                .WIDTH_ACC  (WIDTH_ACC),
                .IGNORE_BIT (IGNORE_BIT),
                .SIGNED     (SIGNED)
            ) u_lane (
                .mode_i (w_mode),
                .acc_i  (w_a),
                .data_i (in_data_i[i*WIDTH_IN +: WIDTH_IN]),
                .sum_o  (w_sum[i*WIDTH_ACC +: WIDTH_ACC]),
                .ovf_o  (w_ovf[i])
            );
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sticky_d    = sticky_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            HOLD: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                if (w_accept) begin
                    mode_d   = w_mode;
                    acc_d    = w_sum;
                    cnt_d    = w_cnt_next;
                    sticky_d = w_sticky_next;
                    state_d  = ACCUM;
                    if (in_last_i) begin
                        out_data_d  = w_sum;
                        out_count_d = w_cnt_next;
                        out_ovf_d   = w_sticky_next;
                        out_valid_d = 1'b1;
                        state_d     = HOLD;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 2'd0;
            acc_q       <= '0;
            cnt_q       <= '0;
            sticky_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sticky_q    <= sticky_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_count_o = out_count_q;
    assign out_ovf_o   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_accum_lanes.sv
// ============================================================================
// Module  : tb_adder_accum_lanes
// Brief   : Self-checking bench: default, SIGNED=1 and WIDTH_ACC=16 instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adder_accum_lanes;

`ifdef ACC_SAT_EN
    localparam logic [15:0] W_V4  = 16'hFFFF;
    localparam logic [15:0] W_V5  = 16'hFFFF;
    localparam logic        W_OVF = 1'b1;
`else
    localparam logic [15:0] W_V4  = 16'h0001;
    localparam logic [15:0] W_V5  = 16'h0000;
    localparam logic        W_OVF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic        in_valid, in_first, in_last, out_ready;
    logic [63:0] in_data;

    logic        rdy_a, vld_a, rdy_s, vld_s, rdy_w, vld_w;
    logic [95:0] data_a, data_s;
    logic [63:0] data_w;
    logic [15:0] cnt_a, cnt_s, cnt_w;
    logic [3:0]  ovf_a, ovf_s, ovf_w;

    always #5 clk = ~clk;

    adder_accum_lanes #(.LANES(4), .WIDTH_IN(16), .WIDTH_ACC(24), .IGNORE_BIT(4), .SIGNED(0)) dut_a (
        .clk(clk), .rst(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(rdy_a),
        .in_first_i(in_first), .in_last_i(in_last), .in_data_i(in_data),
        .out_valid_o(vld_a), .out_ready_i(out_ready), .out_data_o(data_a),
        .out_count_o(cnt_a), .out_ovf_o(ovf_a));

    adder_accum_lanes #(.LANES(4), .WIDTH_IN(16), .WIDTH_ACC(24), .IGNORE_BIT(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(rdy_s),
        .in_first_i(in_first), .in_last_i(in_last), .in_data_i(in_data),
        .out_valid_o(vld_s), .out_ready_i(out_ready), .out_data_o(data_s),
        .out_count_o(cnt_s), .out_ovf_o(ovf_s));

    adder_accum_lanes #(.LANES(4), .WIDTH_IN(16), .WIDTH_ACC(16), .IGNORE_BIT(4), .SIGNED(0)) dut_w (
        .clk(clk), .rst(rst), .mode_i(mode), .in_valid_i(in_valid), .in_ready_o(rdy_w),
        .in_first_i(in_first), .in_last_i(in_last), .in_data_i(in_data),
        .out_valid_o(vld_w), .out_ready_i(out_ready), .out_data_o(data_w),
        .out_count_o(cnt_w), .out_ovf_o(ovf_w));

    typedef struct {
        logic [1:0]  mode;
        logic        first0;
        int          nb;
        logic [63:0] b0;
        logic [63:0] b1;
        logic [95:0] exp_a;
        logic [15:0] cnt;
        logic [23:0] s0;
        logic [15:0] w0;
        logic        wovf;
    } vec_t;

    typedef struct {
        logic [95:0] a;
        logic [15:0] cnt;
        logic [23:0] s0;
        logic [15:0] w0;
        logic        wovf;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: a result is taken on each negedge where the handshake will complete.
    always @(negedge clk) begin
        if (!rst && vld_a && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 96'(vld_a), 96'h0);
            end else begin
                mon_e = sb.pop_front();
                check("data_a",  data_a, mon_e.a);
                check("count_a", 96'(cnt_a), 96'(mon_e.cnt));
                check("ovf_a",   96'(ovf_a), 96'h0);
                check("lane0_signed", 96'(data_s[23:0]), 96'(mon_e.s0));
                check("lane0_w16",    96'(data_w[15:0]), 96'(mon_e.w0));
                check("ovf0_w16",     96'(ovf_w[0]),     96'(mon_e.wovf));
            end
        end
    end

    task automatic drive_beat(input logic [1:0] m, input logic [63:0] d, input logic f, input logic l);
        int guard;
        guard    = 0;
        mode     = m;
        in_data  = d;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        while (!rdy_a && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) check("beat_accept_timeout", 96'(rdy_a), 96'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_exp(input logic [95:0] a, input logic [15:0] c, input logic [23:0] s0,
                            input logic [15:0] w0, input logic wo);
        exp_t e;
        e.a = a; e.cnt = c; e.s0 = s0; e.w0 = w0; e.wovf = wo;
        sb.push_back(e);
    endtask

    task automatic send_vec(input int i);
        push_exp(vecs[i].exp_a, vecs[i].cnt, vecs[i].s0, vecs[i].w0, vecs[i].wovf);
        drive_beat(vecs[i].mode, vecs[i].b0, vecs[i].first0, vecs[i].nb == 1);
        if (vecs[i].nb == 2) drive_beat(vecs[i].mode, vecs[i].b1, 1'b0, 1'b1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1);
    end

    initial begin
        int  guard;
        logic seen;

        vecs[0] = '{2'd0, 1'b1, 2, 64'h0000_FFFF_1234_000F, 64'h0000_0001_1111_0001,
                    {24'h000000, 24'h010000, 24'h002345, 24'h000010}, 16'd2, 24'h000010, 16'h0010, 1'b0};
        vecs[1] = '{2'd1, 1'b1, 2, 64'h0000_FFFF_1234_000F, 64'h0000_0001_1111_0001,
                    {24'h000000, 24'h00FFFF, 24'h002345, 24'h00000F}, 16'd2, 24'h00000F, 16'h000F, 1'b0};
        vecs[2] = '{2'd2, 1'b1, 2, 64'h0000_FFFF_1234_000F, 64'h0000_0001_1111_0001,
                    {24'h000000, 24'h00FFF0, 24'h002340, 24'h000000}, 16'd2, 24'h000000, 16'h0000, 1'b0};
        vecs[3] = '{2'd3, 1'b0, 1, 64'hABCD_8000_0001_1234, 64'h0,
                    {24'h00ABCD, 24'h008000, 24'h000001, 24'h001234}, 16'd1, 24'h001234, 16'h1234, 1'b0};
        vecs[4] = '{2'd0, 1'b1, 2, 64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0001_0002,
                    {24'h000000, 24'h000000, 24'h008000, 24'h010001}, 16'd2, 24'h000001, W_V4, W_OVF};
        vecs[5] = '{2'd0, 1'b1, 2, 64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0001,
                    {24'h000000, 24'h000000, 24'h000000, 24'h010000}, 16'd2, 24'h000000, W_V5, W_OVF};
        vecs[6] = '{2'd1, 1'b1, 2, 64'h0000_0000_00F8_0008, 64'h0000_0000_0009_0008,
                    {24'h000000, 24'h000000, 24'h000109, 24'h000018}, 16'd2, 24'h000018, 16'h0018, 1'b0};

        rst = 1'b1; mode = 2'd0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 96'(vld_a), 96'h0);
        check("rst_out_data",  data_a, 96'h0);
        check("rst_out_count", 96'(cnt_a), 96'h0);
        check("rst_out_ovf",   96'(ovf_a), 96'h0);
        check("rst_in_ready",  96'(rdy_a), 96'h0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", 96'(rdy_a), 96'h1);

        for (int i = 0; i < 7; i++) send_vec(i);

        // Restart mid-frame: the TRUNC partial is dropped and EXACT is relatched.
        push_exp({72'h0, 24'h000007}, 16'd2, 24'h000007, 16'h0007, 1'b0);
        drive_beat(2'd2, 64'h5, 1'b1, 1'b0);
        drive_beat(2'd2, 64'h7, 1'b0, 1'b0);
        drive_beat(2'd0, 64'h3, 1'b1, 1'b0);
        drive_beat(2'd2, 64'h4, 1'b0, 1'b1);

        // Backpressure on a single-beat frame.
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_exp({48'h0, 24'h000042, 24'h001234}, 16'd1, 24'h001234, 16'h1234, 1'b0);
        drive_beat(2'd0, 64'h0000_0000_0042_1234, 1'b1, 1'b1);
        check("latency_out_valid", 96'(vld_a), 96'h1);
        repeat (5) begin
            @(negedge clk);
            check("hold_in_ready", 96'(rdy_a), 96'h0);
            check("hold_out_data", data_a, {48'h0, 24'h000042, 24'h001234});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_out_valid", 96'(vld_a), 96'h0);
        check("post_hs_in_ready",  96'(rdy_a), 96'h1);
        check("post_hs_out_data",  data_a, {48'h0, 24'h000042, 24'h001234});

        // Asynchronous reset in the middle of a frame.
        drive_beat(2'd0, 64'h5, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out_data",  data_a, 96'h0);
        check("arst_out_count", 96'(cnt_a), 96'h0);
        check("arst_out_valid", 96'(vld_a), 96'h0);
        check("arst_in_ready",  96'(rdy_a), 96'h0);
        check("arst_w_data",    96'(data_w), 96'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (vld_a) seen = 1'b1;
        end
        check("no_stale_result", 96'(seen), 96'h0);
        send_vec(3);

        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        check("scoreboard_drained", 96'(sb.size()), 96'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
